// File: rtl/prefetch_buffer.sv
// prefetch_buffer: instruction prefetch queue between memory and the 6502 decoder.
//
// Reads MEM_BYTES bytes per memory access into a DEPTH-byte FIFO, keeping at most one
// read outstanding. Whole instructions (opcode + 0..2 operand bytes) go to decode
// through a valid/ready handshake. A flush (taken branch) empties the queue and
// redirects fetch.
//
// Ports:
//   clk_i, rstn_i            clock, asynchronous active-low reset
//   flush_i, flush_pc_i      redirect request and target address
//   mem_req_o, mem_addr_o    memory read request and address (stable until mem_valid_i)
//   mem_valid_i, mem_data_i  read response, little-endian bytes
//   peek_opcode_o            head byte, used by the decoder to look up the length
//   instr_len_i              instruction length 1..3 (0 is treated as 1)
//   instr_valid_o/ready_i    instruction handshake
//   opcode_o, operand_o      instruction bytes; absent operand bytes read 0
//   instr_pc_o               address of the opcode byte
//   occupancy_o              bytes held in the queue
//   stall_cnt_o              decoder starvation counter
//
// Optional feature macro: PREFETCH_STATS_EN enables the saturating stall counter;
// without it stall_cnt_o is tied to 0.

module prefetch_buffer #(
    parameter int unsigned        ADDR_W    = 16,
    parameter int unsigned        DEPTH     = 8,
    parameter int unsigned        MEM_BYTES = 3,
    parameter logic [ADDR_W-1:0]  RESET_PC  = '0
) (
    input  logic                         clk_i,
    input  logic                         rstn_i,
    input  logic                         flush_i,
    input  logic [ADDR_W-1:0]            flush_pc_i,
    output logic                         mem_req_o,
    output logic [ADDR_W-1:0]            mem_addr_o,
    input  logic                         mem_valid_i,
    input  logic [8*MEM_BYTES-1:0]       mem_data_i,
    output logic [7:0]                   peek_opcode_o,
    input  logic [1:0]                   instr_len_i,
    output logic                         instr_valid_o,
    input  logic                         instr_ready_i,
    output logic [7:0]                   opcode_o,
    output logic [15:0]                  operand_o,
    output logic [ADDR_W-1:0]            instr_pc_o,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy_o,
    output logic [15:0]                  stall_cnt_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    typedef enum logic [1:0] {StIdle, StReq, StDiscard} state_e;

    state_e              state_q, state_d;
    logic [7:0]          queue_q [DEPTH];
    logic [7:0]          queue_d [DEPTH];
    logic [PTR_W-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d, head_pc_q, head_pc_d;
    logic [ADDR_W-1:0]   req_addr_q, req_addr_d;

    logic [1:0]          len;
    logic                push, pop, space_ok;

    // Length 0 from the decoder table is treated as a 1-byte instruction.
    assign len = (instr_len_i == 2'd0) ? 2'd1 : instr_len_i;

    assign peek_opcode_o = queue_q[head_q];
    assign opcode_o      = queue_q[head_q];
    assign operand_o     = {(len == 2'd3) ? queue_q[head_q + PTR_W'(2)] : 8'h00,
                            (len >= 2'd2) ? queue_q[head_q + PTR_W'(1)] : 8'h00};
    assign instr_pc_o    = head_pc_q;
    assign occupancy_o   = count_q;
    assign mem_addr_o    = req_addr_q;

    assign instr_valid_o = (count_q >= CNT_W'(len)) && !flush_i;
    assign pop           = instr_valid_o && instr_ready_i;
    assign push          = (state_q == StReq) && mem_valid_i && !flush_i;
    // Uses the registered count, ignoring any pop this cycle.
    assign space_ok      = (CNT_W'(DEPTH) - count_q) >= CNT_W'(MEM_BYTES);

    always_comb begin
        state_d    = state_q;
        mem_req_o  = 1'b0;
        req_addr_d = req_addr_q;
        unique case (state_q)
            StIdle: begin
                if (!flush_i && space_ok) begin
                    state_d    = StReq;
                    req_addr_d = fetch_pc_q;
                end
            end
            StReq: begin
                mem_req_o = 1'b1;
                if (mem_valid_i) begin
                    state_d = StIdle;
                end else if (flush_i) begin
                    state_d = StDiscard;
                end
            end
            StDiscard: begin
                // Stale response still owed by memory; keep the old request up.
                mem_req_o = 1'b1;
                if (mem_valid_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        queue_d    = queue_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        fetch_pc_d = fetch_pc_q;
        head_pc_d  = head_pc_q;
        if (push) begin
            for (int i = 0; i < int'(MEM_BYTES); i++) begin
                queue_d[tail_q + PTR_W'(i)] = mem_data_i[8*i +: 8];
            end
            tail_d     = tail_q + PTR_W'(MEM_BYTES);
            fetch_pc_d = fetch_pc_q + ADDR_W'(MEM_BYTES);
        end
        count_d = count_q + (push ? CNT_W'(MEM_BYTES) : CNT_W'(0))
                          - (pop ? CNT_W'(len) : CNT_W'(0));
        if (pop) begin
            head_d    = head_q + PTR_W'(len);
            head_pc_d = head_pc_q + ADDR_W'(len);
        end
        if (flush_i) begin
            count_d    = '0;
            head_d     = tail_q;
            fetch_pc_d = flush_pc_i;
            head_pc_d  = flush_pc_i;
        end
    end

`ifdef PREFETCH_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (instr_ready_i && !instr_valid_o && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`else
    assign stall_cnt_o = 16'h0000;
`endif

    always_ff @(posedge clk_i, negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= StIdle;
            for (int i = 0; i < int'(DEPTH); i++) begin
                queue_q[i] <= 8'h00;
            end
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            fetch_pc_q <= RESET_PC;
            head_pc_q  <= RESET_PC;
            req_addr_q <= RESET_PC;
`ifdef PREFETCH_STATS_EN
            stall_cnt_q <= 16'h0000;
`endif
        end else begin
            state_q    <= state_d;
            queue_q    <= queue_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            fetch_pc_q <= fetch_pc_d;
            head_pc_q  <= head_pc_d;
            req_addr_q <= req_addr_d;
`ifdef PREFETCH_STATS_EN
            stall_cnt_q <= stall_cnt_d;
`endif
        end
    end

endmodule

// File: doc/prefetch_buffer.md
Name: prefetch_buffer

Overview:
Parametrised instruction prefetch queue that sits between memory and the decoder. It replaces the single-shot fetch path with a byte FIFO of configurable depth. It issues memory reads ahead of execution and holds at most one request outstanding. It presents whole variable-length 6502 instructions (opcode + 0..2 operand bytes) to decode with a valid/ready handshake, and discards stale data on a taken branch (flush).

Parameters:
ADDR_W, 16, fetch/instruction address width.
DEPTH, 8, byte capacity of queue; power of two, >= 2*MEM_BYTES.
MEM_BYTES, 3, bytes returned per memory access, little-endian (byte 0 = lowest address, bits [7:0]).
RESET_PC, 16'h0000, fetch and head PC after reset.

Ports:
clk_i  in  1  clock
rstn_i  in  1  asynchronous active-low reset
flush_i  in  1  taken branch / redirect
flush_pc_i  in  ADDR_W  redirect target
mem_req_o  out  1  read request
mem_addr_o  out  ADDR_W  read address
mem_valid_i  in  1  read data valid
mem_data_i  in  8*MEM_BYTES  read data
peek_opcode_o  out  8  byte at queue head, combinational, for length lookup
instr_len_i  in  2  length (1..3) of peek_opcode_o, from decoder table, combinational
instr_valid_o  out  1  full instruction available
instr_ready_i  in  1  decoder accepts
opcode_o  out  8  instruction opcode
operand_o  out  16  operand bytes {byte2,byte1}; absent bytes read 0
instr_pc_o  out  ADDR_W  address of opcode byte
occupancy_o  out  $clog2(DEPTH+1)  bytes held
stall_cnt_o  out  16  decoder starvation counter (see Optional Feature)

Behaviour:
- One clock, clk_i; reset asynchronous active-low on rstn_i. All state in one always_ff @(posedge clk_i, negedge rstn_i).
- Reset values:
  - count=0, head/tail=0, fetch_pc=head_pc=RESET_PC, FSM=IDLE.
  - mem_req_o=0, mem_addr_o=RESET_PC, instr_valid_o=0, opcode_o/operand_o=0, occupancy_o=0, stall_cnt_o=0.
  - Reset mid-request abandons the request; memory must tolerate this.
- FSM states:
  - IDLE: mem_req_o=0. Go to REQ next cycle when (DEPTH-count) >= MEM_BYTES and no flush_i.
  - REQ: mem_req_o=1, mem_addr_o=fetch_pc, both held stable until mem_valid_i.
    - mem_valid_i, no flush_i: write MEM_BYTES bytes at tail, fetch_pc += MEM_BYTES (mod 2^ADDR_W), go to IDLE.
    - flush_i with mem_valid_i same cycle: drop data, go to IDLE.
    - flush_i without mem_valid_i: go to DISCARD.
  - DISCARD: mem_req_o=1 with the old address; on mem_valid_i drop data, go to IDLE.
  - Space is checked against registered count before this cycle's pop (conservative). Minimum request-to-request spacing is 1 IDLE cycle.
- Output side:
  - instr_valid_o = (count >= instr_len_i) && !flush_i; instr_len_i==0 is treated as 1.
  - opcode_o = queue[head]; operand_o byte1 = queue[head+1] if len>=2 else 0, byte2 = queue[head+2] if len==3 else 0; indices wrap mod DEPTH.
  - Pop on instr_valid_o && instr_ready_i: head += len, head_pc += len (mod 2^ADDR_W).
- Same-cycle push and pop: count_next = count + (push ? MEM_BYTES : 0) - (pop ? len : 0). Never overflows or underflows.
- Flush (highest priority): count=0, head=tail, fetch_pc=head_pc=flush_pc_i, pop suppressed.
  - Next IDLE cycle goes to REQ with flush_pc_i, unless in DISCARD, which first waits for the stale response.
- Address wrap: 0xFFFF+1 = 0x0000 for both fetch_pc and head_pc.

Optional Feature:
PREFETCH_STATS_EN:
- Defined: stall_cnt_o increments each cycle instr_ready_i && !instr_valid_o, saturating at 16'hFFFF; cleared only by reset.
- Undefined: stall_cnt_o tied to 0 and no counter logic.

Test Plan:
- Reset release, RESET_PC=16'h8000, memory 1-cycle latency, ready=0 -> requests 8000, 8003; then mem_req_o stays 0; occupancy_o=6.
- Memory bytes A9 05 8D 00 02 EA, lengths 2/3/1, ready=1 -> (A9,0005,8000), (8D,0200,8002), (EA,0000,8005), one per cycle once buffered.
- flush_i with flush_pc_i=C000 while REQ at 8006 and mem_valid_i delayed 3 cycles -> DISCARD, response dropped, next mem_addr_o=C000, first instr_pc_o=C000, instr_valid_o=0 in flush cycle.
- flush_i coincident with mem_valid_i and a pop -> data dropped, no pop, occupancy_o=0, next request at flush_pc_i.
- RESET_PC=16'hFFFE, bytes at FFFE,FFFF,0000 = 20 34 12, len 3 -> requests FFFE then 0001; opcode 20, operand 1234, pc FFFE.
- PREFETCH_STATS_EN defined, mem_valid_i held 0 for 10 cycles with ready=1 after reset -> stall_cnt_o=10; undefined -> stall_cnt_o=0.
